// File: rtl/bench_sequencer.sv
// bench_sequencer: steps a CPU under test through a series of benchmarks.
// For each benchmark the CPU is held in reset for one LOAD cycle with the
// benchmark index on test_selector, released for RUN_CYCLES cycles, then
// put back in reset for one DRAIN cycle while test_done pulses and
// cycle_count reports how many cycles the benchmark ran.
//
// Ports:
//   clk           single clock, all logic on the rising edge
//   reset         synchronous active-high block reset
//   start         request to begin a sequence (ignored while busy)
//   abort         terminate any sequence in progress, return to IDLE
//   cpu_halt      CPU halt indication (only used with BENCH_HALT_DETECT_EN)
//   cpu_reset     reset driven to the CPU under test
//   test_selector benchmark index driven to the CPU
//   busy          high in LOAD, RUN and DRAIN
//   test_done     one-cycle pulse in DRAIN at the end of each benchmark
//   all_done      high while in DONE
//   cycle_count   run cycles of the most recently completed benchmark
//
// Configuration macro: BENCH_HALT_DETECT_EN -- when defined, cpu_halt in RUN
// ends the benchmark early (RUN_CYCLES stays the upper bound).

module bench_sequencer #(
  parameter int unsigned NUM_TESTS  = 12,
  parameter int unsigned FIRST_TEST = 1,
  parameter int unsigned RUN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       cpu_halt,
  output logic       cpu_reset,
  output logic [3:0] test_selector,
  output logic       busy,
  output logic       test_done,
  output logic       all_done,
  output logic [7:0] cycle_count
);

  localparam int unsigned LAST_TEST = FIRST_TEST + NUM_TESTS - 1;
  localparam logic [3:0]  FIRST_SEL = 4'(FIRST_TEST);
  localparam logic [3:0]  LAST_SEL  = 4'(LAST_TEST);
  localparam logic [7:0]  RUN_LAST  = 8'(RUN_CYCLES - 1);

  // Reject configurations the 4-bit selector or 8-bit counter cannot hold.
  if (NUM_TESTS < 1 || LAST_TEST > 15) begin : g_bad_test_range
    $error("bench_sequencer: FIRST_TEST+NUM_TESTS-1 must be within 0..15 and NUM_TESTS >= 1");
  end
  if (RUN_CYCLES < 2 || RUN_CYCLES > 255) begin : g_bad_run_cycles
    $error("bench_sequencer: RUN_CYCLES must be within 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] run_cnt;
  logic       halt_hit;

  // Early-termination source for RUN.
`ifdef BENCH_HALT_DETECT_EN
  assign halt_hit = cpu_halt;
`else
  logic unused_halt;
  assign unused_halt = cpu_halt;
  assign halt_hit    = 1'b0;
`endif

  // Sequencer FSM; every output is set on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      run_cnt       <= 8'd0;
      cpu_reset     <= 1'b1;
      test_selector <= 4'd0;
      busy          <= 1'b0;
      test_done     <= 1'b0;
      all_done      <= 1'b0;
      cycle_count   <= 8'd0;
    end else if (abort) begin
      // cycle_count keeps the last completed benchmark's result.
      state         <= S_IDLE;
      cpu_reset     <= 1'b1;
      test_selector <= 4'd0;
      busy          <= 1'b0;
      test_done     <= 1'b0;
      all_done      <= 1'b0;
    end else begin
      test_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_LOAD;
            test_selector <= FIRST_SEL;
            cpu_reset     <= 1'b1;
            busy          <= 1'b1;
            all_done      <= 1'b0;
          end
        end
        S_LOAD: begin
          state     <= S_RUN;
          run_cnt   <= 8'd0;
          cpu_reset <= 1'b0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 8'd1;
          // run_cnt counts completed RUN cycles, so +1 includes this one.
          if (run_cnt == RUN_LAST || halt_hit) begin
            state       <= S_DRAIN;
            cpu_reset   <= 1'b1;
            test_done   <= 1'b1;
            cycle_count <= run_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (test_selector == LAST_SEL) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end else begin
            state         <= S_LOAD;
            test_selector <= test_selector + 4'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
          all_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bench_sequencer.sv
// Testbench for bench_sequencer: a default-sized instance and a minimal
// one-test instance (FIRST_TEST=15, RUN_CYCLES=2) share the same stimulus.
// Expected outputs come from a timeline model: while a sequence is active
// the outputs are a function of the cycle offset since the first LOAD.

module tb_bench_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, cpu_halt;

  logic       cpu_reset_o     [2];
  logic [3:0] test_selector_o [2];
  logic       busy_o          [2];
  logic       test_done_o     [2];
  logic       all_done_o      [2];
  logic [7:0] cycle_count_o   [2];

  bench_sequencer #(.NUM_TESTS(12), .FIRST_TEST(1), .RUN_CYCLES(16)) dut_main (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cpu_halt(cpu_halt),
    .cpu_reset(cpu_reset_o[0]), .test_selector(test_selector_o[0]), .busy(busy_o[0]),
    .test_done(test_done_o[0]), .all_done(all_done_o[0]), .cycle_count(cycle_count_o[0])
  );

  bench_sequencer #(.NUM_TESTS(1), .FIRST_TEST(15), .RUN_CYCLES(2)) dut_edge (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cpu_halt(cpu_halt),
    .cpu_reset(cpu_reset_o[1]), .test_selector(test_selector_o[1]), .busy(busy_o[1]),
    .test_done(test_done_o[1]), .all_done(all_done_o[1]), .cycle_count(cycle_count_o[1])
  );

  int total = 0;
  int bad   = 0;

  // Model: idle / active (t = cycles since LOAD entry) / done.
  bit m_active [2];
  bit m_done   [2];
  int m_t      [2];
  int m_cc     [2];
  int tdone_cnt = 0;

  function automatic int nt_of(int i); return (i == 0) ? 12 : 1;  endfunction
  function automatic int ft_of(int i); return (i == 0) ? 1  : 15; endfunction
  function automatic int rc_of(int i); return (i == 0) ? 16 : 2;  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit a, input bit s);
    for (int i = 0; i < 2; i++) begin
      int p;
      p = rc_of(i) + 2;
      if (r) begin
        m_active[i] = 0; m_done[i] = 0; m_cc[i] = 0;
      end else if (a) begin
        m_active[i] = 0; m_done[i] = 0;
      end else if (m_active[i]) begin
        m_t[i]++;
        if (m_t[i] == nt_of(i) * p) begin
          m_active[i] = 0; m_done[i] = 1;
        end else if (m_t[i] % p == rc_of(i) + 1) begin
          m_cc[i] = rc_of(i);
        end
      end else if (s) begin
        m_active[i] = 1; m_done[i] = 0; m_t[i] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int p, ph, e_sel;
      bit e_rst, e_busy, e_td, e_ad;
      string pfx;
      pfx = (i == 0) ? "main" : "edge";
      p = rc_of(i) + 2;
      if (m_active[i]) begin
        ph     = m_t[i] % p;
        e_sel  = ft_of(i) + m_t[i] / p;
        e_rst  = !(ph >= 1 && ph <= rc_of(i));
        e_busy = 1;
        e_td   = (ph == rc_of(i) + 1);
        e_ad   = 0;
      end else if (m_done[i]) begin
        e_sel = ft_of(i) + nt_of(i) - 1;
        e_rst = 1; e_busy = 0; e_td = 0; e_ad = 1;
      end else begin
        e_sel = 0;
        e_rst = 1; e_busy = 0; e_td = 0; e_ad = 0;
      end
      if (i == 0 && e_td) tdone_cnt++;
      check({pfx, ".cpu_reset"},     32'(cpu_reset_o[i]),     32'(e_rst));
      check({pfx, ".test_selector"}, 32'(test_selector_o[i]), 32'(e_sel));
      check({pfx, ".busy"},          32'(busy_o[i]),          32'(e_busy));
      check({pfx, ".test_done"},     32'(test_done_o[i]),     32'(e_td));
      check({pfx, ".all_done"},      32'(all_done_o[i]),      32'(e_ad));
      check({pfx, ".cycle_count"},   32'(cycle_count_o[i]),   32'(m_cc[i]));
    end
  endtask

  // One clock: drive inputs, let the DUT sample them, advance model, compare.
  task automatic step(input bit s, input bit a, input bit r);
    start    = s;
    abort    = a;
    reset    = r;
    cpu_halt = 1'($urandom_range(1));
    @(posedge clk);
    model_update(r, a, s);
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; cpu_halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_done[i] = 0; m_t[i] = 0; m_cc[i] = 0;
    end
    #2;

    // Reset, with start/abort asserted to show reset wins.
    step(1, 1, 1);
    step(1, 0, 1);
    step(0, 0, 0);

    // Full default sequence from a single start pulse, random cpu_halt.
    tdone_cnt = 0;
    step(1, 0, 0);
    repeat (220) step(0, 0, 0);
    check("main.test_done_pulses", 32'(tdone_cnt), 32'd12);

    // start held high across an entire sequence, then restart from DONE.
    repeat (230) step(1, 0, 0);
    repeat (5) step(0, 0, 0);

    // Abort in the 5th RUN cycle of test 5, with a simultaneous start.
    step(0, 1, 0);
    step(1, 0, 0);
    repeat (77) step(0, 0, 0);
    check("main.sel_before_abort", 32'(test_selector_o[0]), 32'd5);
    step(1, 1, 0);
    repeat (20) step(0, 0, 0);

    // Reset during DRAIN of test 3.
    step(1, 0, 0);
    repeat (53) step(0, 0, 0);
    check("main.drain_test3", 32'(test_done_o[0]), 32'd1);
    step(0, 0, 1);
    tdone_cnt = 0;
    repeat (30) step(0, 0, 0);
    check("main.no_done_after_reset", 32'(tdone_cnt), 32'd0);

    // Randomized traffic.
    repeat (4000) begin
      bit s, a, r;
      s = ($urandom_range(39) == 0);
      a = ($urandom_range(399) == 0);
      r = ($urandom_range(599) == 0);
      step(s, a, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bench_sequencer.md
BENCH_SEQUENCER -- requirements
Module: bench_sequencer

Interface
REQ-001 The parameter list SHALL be: NUM_TESTS, 12, number of benchmarks run per sequence.
REQ-002 The parameter list SHALL be: FIRST_TEST, 1, selector value of the first benchmark.
REQ-003 The parameter list SHALL be: RUN_CYCLES, 16, cycles cpu_reset is held low per benchmark (legal 2..255).
REQ-004 Ports SHALL be: clk  input  1  single clock, all logic on rising edge.
REQ-005 Ports SHALL be: reset  input  1  synchronous, active-high block reset.
REQ-006 Ports SHALL be: start  input  1  one-cycle request to begin a sequence.
REQ-007 Ports SHALL be: abort  input  1  terminate any sequence in progress.
REQ-008 Ports SHALL be: cpu_halt  input  1  CPU halt indication (used only per REQ-028).
REQ-009 Ports SHALL be: cpu_reset  output  1  reset driven to the cpu under test.
REQ-010 Ports SHALL be: test_selector  output  4  benchmark index driven to the cpu.
REQ-011 Ports SHALL be: busy  output  1  high in every state except IDLE and DONE.
REQ-012 Ports SHALL be: test_done  output  1  one-cycle pulse at the end of each benchmark.
REQ-013 Ports SHALL be: all_done  output  1  high while in DONE.
REQ-014 Ports SHALL be: cycle_count  output  8  run cycles of the most recently completed benchmark.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN, DRAIN, DONE; all outputs registered.
REQ-016 IDLE: cpu_reset=1, test_selector=0; start -> LOAD with test_selector=FIRST_TEST.
REQ-017 LOAD: exactly one cycle, cpu_reset=1, run counter cleared -> RUN.
REQ-018 RUN: cpu_reset=0, run counter increments each cycle; after RUN_CYCLES cycles in RUN -> DRAIN.
REQ-019 DRAIN: exactly one cycle, cpu_reset=1, test_done=1, cycle_count latched with the RUN cycle total.
REQ-020 From DRAIN: if test_selector == FIRST_TEST+NUM_TESTS-1 -> DONE, else test_selector increments by 1 -> LOAD.
REQ-021 Per-benchmark period SHALL be RUN_CYCLES+2 cycles (18 at default); cpu_reset low exactly RUN_CYCLES consecutive cycles.
REQ-022 DONE: cpu_reset=1, all_done=1, test_selector holds last value; start -> LOAD with FIRST_TEST and all_done cleared.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort in any state SHALL force IDLE on the next edge (cpu_reset=1, selector 0, all_done=0) with no test_done pulse; abort wins over simultaneous start.
REQ-025 FIRST_TEST+NUM_TESTS-1 > 15 or RUN_CYCLES outside 2..255 SHALL be an elaboration error.

Reset
REQ-026 reset SHALL place FSM in IDLE on the next rising clk edge, overriding start/abort/cpu_halt.
REQ-027 Reset values SHALL be: cpu_reset=1, test_selector=0, busy=0, test_done=0, all_done=0, cycle_count=0; reset mid-RUN discards the current benchmark.

Configuration
REQ-028 With BENCH_HALT_DETECT_EN defined, cpu_halt=1 in RUN SHALL move to DRAIN on the next edge, cycle_count = RUN cycles including the halt cycle; RUN_CYCLES remains the upper bound.
REQ-029 Without BENCH_HALT_DETECT_EN, cpu_halt SHALL be ignored (port retained), every benchmark runs RUN_CYCLES cycles.

Verification
REQ-030 Defaults, start pulse -> selector steps 1..12, each held 18 cycles, cpu_reset low 16 cycles per test, 12 test_done pulses, cycle_count=16, all_done 216 cycles after LOAD entry.
REQ-031 abort asserted during RUN of test 5 -> IDLE next cycle, cpu_reset=1, selector 0, no test_done for test 5.
REQ-032 start held high across whole sequence -> no restart until DONE; in DONE start -> selector=1, all_done=0.
REQ-033 reset asserted during DRAIN of test 3 -> all outputs at reset values next cycle, no further test_done.
REQ-034 BENCH_HALT_DETECT_EN, cpu_halt high on 6th RUN cycle of test 2 -> DRAIN next cycle, cycle_count=6, selector 3 in following LOAD.
REQ-035 NUM_TESTS=1, FIRST_TEST=15, RUN_CYCLES=2 -> selector 15, cpu_reset low 2 cycles, DONE after 4 cycles, no selector wrap.
